// File: rtl/barker_frame_tx.sv
// barker_frame_tx: serialises payload bytes into Barker-preambled 1-bit AXI-Stream frames
// Ports: i_clk/i_rst (async active-high); s_t* = 8-bit payload input stream;
// m_t* = 1-bit output stream (m_tlast on last payload bit); o_busy = not idle;
// o_trunc = pulse when a frame is cut at MAX_BYTES; o_frame_cnt = completed frames.
module barker_frame_tx #(
  parameter int          BARKER_LEN  = 13,
  parameter logic [12:0] BARKER_CODE = 13'b1111100110101,
  parameter int          MAX_BYTES   = 16,
  parameter int          GUARD_BITS  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic        m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        o_busy,
  output logic        o_trunc,
  output logic [15:0] o_frame_cnt
);
  localparam int BW = $clog2(MAX_BYTES + 1);
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GUARD} state_t;
  state_t state, state_nx;
  logic [3:0] pre_idx;
  logic [7:0] sr;
  logic sr_last, sr_full, done;
  logic [2:0] bit_idx;
  logic [BW-1:0] byte_cnt;
  logic [15:0] guard_cnt;
  logic m_hs, s_hs, cap_last;
  assign m_hs = m_tvalid & m_tready;
  assign s_hs = s_tvalid & s_tready;
  assign o_busy = state != IDLE;
  // a byte is marked last either by the source or by hitting the length limit
  assign cap_last = s_tlast | (byte_cnt == BW'(MAX_BYTES - 1));
  always_comb begin
    state_nx = state;
    m_tvalid = 1'b0;
    m_tdata = 1'b0;
    m_tlast = 1'b0;
    s_tready = 1'b0;
    case (state)
      IDLE: state_nx = s_tvalid ? PREAMBLE : IDLE;
      PREAMBLE: begin
        m_tvalid = 1'b1;
        m_tdata = BARKER_CODE[4'(BARKER_LEN - 1) - pre_idx];
        s_tready = !sr_full;
        if (m_tready && pre_idx == 4'(BARKER_LEN - 1)) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        m_tvalid = sr_full;
        m_tdata = sr[~bit_idx];
        m_tlast = sr_last & (bit_idx == 3'd7);
        // reload in the same cycle the final bit leaves, keeping the bit stream gapless
        s_tready = !done & (!sr_full | (m_tready & bit_idx == 3'd7));
        if (sr_full && m_tready && sr_last && bit_idx == 3'd7) state_nx = (GUARD_BITS > 0) ? GUARD : IDLE;
      end
      default: begin
        m_tvalid = 1'b1;
        if (m_tready && guard_cnt == 16'(GUARD_BITS - 1)) state_nx = IDLE;
      end
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      pre_idx <= '0;
      sr <= '0;
      sr_last <= 1'b0;
      sr_full <= 1'b0;
      done <= 1'b0;
      bit_idx <= '0;
      byte_cnt <= '0;
      guard_cnt <= '0;
      o_trunc <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      state <= state_nx;
      o_trunc <= s_hs & !s_tlast & (byte_cnt == BW'(MAX_BYTES - 1));
      if (m_hs && m_tlast) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (state == PREAMBLE && m_hs) pre_idx <= pre_idx + 4'd1;
      if (state == GUARD && m_hs) guard_cnt <= guard_cnt + 16'd1;
      if (state == PAYLOAD && m_hs) begin
        bit_idx <= bit_idx + 3'd1;
        if (bit_idx == 3'd7) sr_full <= 1'b0;
      end
      if (s_hs) begin
        sr <= s_tdata;
        sr_full <= 1'b1;
        sr_last <= cap_last;
        done <= cap_last;
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (state_nx == IDLE) begin
        pre_idx <= '0;
        byte_cnt <= '0;
        done <= 1'b0;
        guard_cnt <= '0;
        sr_full <= 1'b0;
        sr_last <= 1'b0;
      end
    end
  end
endmodule
